// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
// Deglitch length applies only when PWM_CAPTURE_DEGLITCH_EN is defined.
`timescale 1ns/1ps
package pwm_pkg;

    typedef logic [1:0] pwm_state_t;

    localparam pwm_state_t IDLE = 2'd0;
    localparam pwm_state_t HIGH = 2'd1;
    localparam pwm_state_t LOW  = 2'd2;

    localparam int unsigned DEGLITCH_LEN = 3;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizer, optional deglitch filter and registered rise/fall detect for pwm_in.
// Define PWM_CAPTURE_DEGLITCH_EN to require DEGLITCH_LEN stable samples before a level change.
`timescale 1ns/1ps
module pwm_sync_edge
    import pwm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last;
    logic                   filt;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;

    assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int unsigned DgW = $clog2(DEGLITCH_LEN);

    logic [DgW-1:0] dg_cnt_q;
    logic [DgW-1:0] dg_cnt_d;

    // The third consecutive differing sample is passed straight through, so the filter
    // adds only DEGLITCH_LEN-1 cycles of latency.
    always_comb begin
        filt     = level_q;
        dg_cnt_d = '0;
        if (sync_last != level_q) begin
            if (dg_cnt_q == DgW'(DEGLITCH_LEN - 1)) begin
                filt = sync_last;
            end else begin
                dg_cnt_d = dg_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dg_cnt_q <= '0;
        end else begin
            dg_cnt_q <= dg_cnt_d;
        end
    end
`else
    assign filt = sync_last;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            level_q <= filt;
            rise_q  <= filt & ~level_q;
            fall_q  <= ~filt & level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input, flags 0 %/100 % duty as stuck.
// Optional input deglitching is enabled with PWM_CAPTURE_DEGLITCH_EN.
`timescale 1ns/1ps
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic level;
    logic rise;
    logic fall;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    pwm_state_t       state_q, state_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] high_reg_q, high_reg_d;
    logic [CNT_W-1:0] per_cap_q, per_cap_d;
    logic             upd_q, upd_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             meas_valid_q, meas_valid_d;
    logic             stuck_q, stuck_d;
    logic             stuck_level_q, stuck_level_d;
    logic [CNT_W-1:0] high_inc;
    logic [CNT_W-1:0] per_inc;

    assign high_inc = (high_cnt_q != CntMax) ? high_cnt_q + CntOne : high_cnt_q;
    assign per_inc  = (per_cnt_q != CntMax) ? per_cnt_q + CntOne : per_cnt_q;

    always_comb begin
        state_d       = state_q;
        high_cnt_d    = high_cnt_q;
        per_cnt_d     = per_cnt_q;
        high_reg_d    = high_reg_q;
        per_cap_d     = per_cap_q;
        upd_d         = 1'b0;
        high_time_d   = high_time_q;
        period_d      = period_q;
        meas_valid_d  = upd_q;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;

        // Outputs are published one cycle after the closing rise was accepted.
        if (upd_q) begin
            high_time_d = high_reg_q;
            period_d    = per_cap_q;
        end

        if (rise || fall) begin
            stuck_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d    = HIGH;
                    high_cnt_d = CntOne;
                    per_cnt_d  = CntOne;
                end
            end
            HIGH: begin
                if (per_cnt_q == CntMax) begin
                    state_d       = IDLE;
                    stuck_d       = 1'b1;
                    stuck_level_d = level;
                end else if (fall) begin
                    state_d    = LOW;
                    high_reg_d = high_cnt_q;
                    per_cnt_d  = per_inc;
                end else begin
                    high_cnt_d = high_inc;
                    per_cnt_d  = per_inc;
                end
            end
            LOW: begin
                if (per_cnt_q == CntMax) begin
                    state_d       = IDLE;
                    stuck_d       = 1'b1;
                    stuck_level_d = level;
                end else if (rise) begin
                    state_d    = HIGH;
                    per_cap_d  = per_cnt_q;
                    upd_d      = 1'b1;
                    high_cnt_d = CntOne;
                    per_cnt_d  = CntOne;
                end else begin
                    per_cnt_d = per_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            high_cnt_q    <= '0;
            per_cnt_q     <= '0;
            high_reg_q    <= '0;
            per_cap_q     <= '0;
            upd_q         <= 1'b0;
            high_time_q   <= '0;
            period_q      <= '0;
            meas_valid_q  <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            high_cnt_q    <= high_cnt_d;
            per_cnt_q     <= per_cnt_d;
            high_reg_q    <= high_reg_d;
            per_cap_q     <= per_cap_d;
            upd_q         <= upd_d;
            high_time_q   <= high_time_d;
            period_q      <= period_d;
            meas_valid_q  <= meas_valid_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign high_time   = high_time_q;
    assign period      = period_q;
    assign meas_valid  = meas_valid_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (CNT_W=8, 10 ns clock).
// Expected values track PWM_CAPTURE_DEGLITCH_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned SYNC_STAGES = 2;
`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int LAT      = SYNC_STAGES + 5;
    // A one-cycle low pulse is filtered out, so the resume waveform keeps a 3-cycle low.
    localparam int RESUME_H = 13;
`else
    localparam int LAT      = SYNC_STAGES + 3;
    localparam int RESUME_H = 15;
`endif

    logic             clk;
    logic             reset_n;
    logic             pwm_in;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic             meas_valid;
    logic             stuck;
    logic             stuck_level;

    pwm_capture #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pwm_in     (pwm_in),
        .high_time  (high_time),
        .period     (period),
        .meas_valid (meas_valid),
        .stuck      (stuck),
        .stuck_level(stuck_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int phase    = 0;
    int wp       = 16;
    int wh       = 0;
    int wg       = -1;
    int last_rise = 0;
    int rises    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: outputs are stable here, then the next waveform sample is driven.
    task automatic step();
        logic nxt;
        @(posedge clk);
        #1;
        cyc++;
        nxt = (phase < wh) || (phase == wg);
        if (nxt && !pwm_in) begin
            last_rise = cyc;
            rises++;
        end
        pwm_in = nxt;
        phase  = (phase == wp - 1) ? 0 : phase + 1;
    endtask

    task automatic set_wave(input int p, input int h, input int g);
        int n;
        n = 0;
        while (phase != 0 && n < 64) begin
            step();
            n++;
        end
        wp = p;
        wh = h;
        wg = g;
    endtask

    task automatic wait_valid(input string tag, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!meas_valid && n < limit);
        chk({tag, "_seen"}, 32'(meas_valid), 1);
    endtask

    task automatic check_meas(input string tag, input int p, input int h);
        chk({tag, "_period"}, 32'(period), p);
        chk({tag, "_high"}, 32'(high_time), h);
        chk({tag, "_latency"}, cyc - last_rise, LAT);
    endtask

    task automatic hold_wait(input string tag, input int total, input int lo, input int hi,
                             input logic lvl);
        int first;
        int nv;
        bit cleared;
        first   = -1;
        nv      = 0;
        cleared = 1'b0;
        for (int i = 1; i <= total; i++) begin
            step();
            if (meas_valid) nv++;
            if (!stuck) cleared = 1'b1;
            if (stuck && cleared && first < 0) first = i;
        end
        chk({tag, "_window"}, 32'(first >= lo && first <= hi), 1);
        chk({tag, "_stuck"}, 32'(stuck), 1);
        chk({tag, "_level"}, 32'(stuck_level), 32'(lvl));
        chk({tag, "_no_valid"}, nv, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nv;
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        repeat (3) step();
        chk("rst_period", 32'(period), 0);
        chk("rst_high", 32'(high_time), 0);
        chk("rst_valid", 32'(meas_valid), 0);
        chk("rst_stuck", 32'(stuck), 0);
        chk("rst_stuck_level", 32'(stuck_level), 0);
        reset_n = 1'b1;

        // P=16 H=5: first rise alone must not report anything.
        set_wave(16, 5, -1);
        nv = 0;
        repeat (20) begin
            step();
            if (meas_valid) nv++;
        end
        chk("first_rise_no_valid", nv, 0);
        wait_valid("m1", 40, n);
        check_meas("m1", 16, 5);
        wait_valid("m2", 40, n);
        chk("m2_gap", n, 16);
        check_meas("m2", 16, 5);
        step();
        chk("pulse_width", 32'(meas_valid), 0);
        chk("hold_period", 32'(period), 16);
        chk("hold_high", 32'(high_time), 5);

        // Duty change 5 -> 10 at a period boundary.
        set_wave(16, 10, -1);
        wait_valid("c1", 40, n);
        check_meas("c1", 16, 5);
        wait_valid("c2", 40, n);
        chk("c2_gap", n, 16);
        check_meas("c2", 16, 10);

        // Held low, then held high, then resume.
        set_wave(16, 0, -1);
        hold_wait("stk0", 300, 230, 265, 1'b0);
        set_wave(16, 16, -1);
        hold_wait("stk1", 300, 230, 265, 1'b1);
        set_wave(16, RESUME_H, -1);
        rises = 0;
        wait_valid("r1", 60, n);
        chk("r1_stuck_clear", 32'(stuck), 0);
        chk("r1_rises", rises, 2);
        check_meas("r1", 16, RESUME_H);

        // Reset in the middle of a period.
        set_wave(16, 5, -1);
        wait_valid("p0", 40, n);
        check_meas("p0", 16, RESUME_H);
        wait_valid("p1", 40, n);
        check_meas("p1", 16, 5);
        repeat (2) step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_period", 32'(period), 0);
        chk("mid_rst_high", 32'(high_time), 0);
        chk("mid_rst_valid", 32'(meas_valid), 0);
        chk("mid_rst_stuck", 32'(stuck), 0);
        step();
        reset_n = 1'b1;
        rises   = 0;
        wait_valid("pr", 60, n);
        chk("pr_rises", rises, 2);
        check_meas("pr", 16, 5);

        // One-cycle high glitch at phase 10 of the low time.
        set_wave(16, 5, 10);
        wait_valid("g0", 40, n);
        check_meas("g0", 16, 5);
`ifdef PWM_CAPTURE_DEGLITCH_EN
        wait_valid("g1", 40, n);
        chk("g1_gap", n, 16);
        check_meas("g1", 16, 5);
`else
        wait_valid("g1", 40, n);
        chk("g1_gap", n, 10);
        check_meas("g1", 10, 5);
        wait_valid("g2", 40, n);
        chk("g2_gap", n, 6);
        check_meas("g2", 6, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the high-time and period counters and outputs.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (minimum 2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port pwm_in  input  1  asynchronous PWM waveform to be measured.
REQ-006 SHALL have port high_time  output  CNT_W  clk cycles pwm_in was high in the last complete period.
REQ-007 SHALL have port period  output  CNT_W  clk cycles between the last two rising edges.
REQ-008 SHALL have port meas_valid  output  1  one-cycle pulse: high_time/period just updated.
REQ-009 SHALL have port stuck  output  1  no edge seen for 2^CNT_W-1 cycles (0 % or 100 % duty).
REQ-010 SHALL have port stuck_level  output  1  pwm_in level while stuck is high.

Function
REQ-011 SHALL pass pwm_in through SYNC_STAGES flops, then detect rise/fall by comparison with one further registered copy (the filtered level).
REQ-012 SHALL implement FSM states IDLE, HIGH, LOW; reset state IDLE.
REQ-013 IDLE: on rise -> HIGH, load both counters with 1; falls ignored; no meas_valid.
REQ-014 HIGH: both counters increment each cycle; on fall -> LOW, capture high counter into an internal high register.
REQ-015 LOW: period counter increments; on rise -> HIGH, drive period=period counter, high_time=internal high register, meas_valid=1 the following cycle, reload both counters with 1.
REQ-016 Counting SHALL be exact: input of period P cycles, high H cycles (1<=H<P) SHALL report period=P, high_time=H.
REQ-017 meas_valid SHALL assert SYNC_STAGES+2 clk cycles after the clk edge that first samples the rising pwm_in.
REQ-018 high_time/period SHALL hold their value between meas_valid pulses.
REQ-019 Period counter reaching 2^CNT_W-1 in HIGH or LOW SHALL force IDLE, set stuck=1, stuck_level=filtered level; counters SHALL saturate, never wrap.
REQ-020 stuck SHALL clear on the next detected edge (either direction); first measurement after stuck SHALL be the second rising edge.
REQ-021 Rise and fall in same cycle cannot occur after filtering; first rising edge after reset SHALL never produce meas_valid.

Reset
REQ-022 reset_n low SHALL immediately clear all flops: state IDLE, high_time=0, period=0, meas_valid=0, stuck=0, stuck_level=0, synchronizer=0.
REQ-023 Reset mid-measurement SHALL discard the partial period; no meas_valid until two rising edges after release.

Configuration
REQ-024 With macro PWM_CAPTURE_DEGLITCH_EN defined, filtered level SHALL change only after 3 consecutive identical synchronized samples differing from it; latency in REQ-017 grows by 2 cycles; pulses under 3 cycles ignored.
REQ-025 Without PWM_CAPTURE_DEGLITCH_EN, filtered level SHALL equal last synchronizer stage; every 1-cycle pulse counts as edges.

Structure
REQ-026 Package pwm_pkg SHALL hold FSM state typedef (IDLE/HIGH/LOW) and the deglitch length constant (3).
REQ-027 Synchronizer, optional deglitch filter and edge detect SHALL be sub-module pwm_sync_edge (outputs level, rise, fall); FSM and counters in pwm_capture.

Verification (bench: CNT_W=8, 10 ns clk)
REQ-028 Periodic pwm_in, P=16, H=5 -> after second rise meas_valid pulses each 16 cycles, period=16, high_time=5.
REQ-029 H changed 5->10 mid-run -> first full period after change reports high_time=10, period=16; no spurious valid.
REQ-030 pwm_in held 0 for 300 cycles -> stuck=1, stuck_level=0 within 255+SYNC_STAGES+1 cycles; held 1 -> stuck_level=1; resuming P=16, H=15 -> stuck clears, period=16, high_time=15.
REQ-031 reset_n pulsed low at cycle 7 of a period -> outputs 0 immediately; next meas_valid only after two rises, values correct.
REQ-032 1-cycle high glitch in LOW phase -> with PWM_CAPTURE_DEGLITCH_EN results unchanged (16/5); without it meas_valid reports the glitch-split period.
